// File: rtl/threshold_ctrl.sv
// Binary threshold stage: binarizes a raster intensity stream against a per-frame
// threshold and recomputes that threshold from frame min/max (or a host value).
module threshold_ctrl #(
  parameter int              WIDTH       = 8,
  parameter int              H_RES       = 640,
  parameter int              V_RES       = 480,
  parameter logic [WIDTH-1:0] INIT_THRESH = WIDTH'(128),
  parameter logic [WIDTH-1:0] HI          = '1,
  parameter logic [WIDTH-1:0] LO          = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             manual,
  input  logic [WIDTH-1:0] thresh_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_I,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof,
  output logic [WIDTH-1:0] thresh,
  output logic [WIDTH-1:0] frame_min,
  output logic [WIDTH-1:0] frame_max,
  output logic             busy
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, UPDATE} state_t;

  state_t           state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [WIDTH-1:0] run_min_q, run_min_d;
  logic [WIDTH-1:0] run_max_q, run_max_d;
  logic [WIDTH-1:0] thresh_q, thresh_d;
  logic [WIDTH-1:0] fmin_q, fmin_d;
  logic [WIDTH-1:0] fmax_q, fmax_d;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] oq_q, oq_d;
  logic             sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;

  logic             accept;
  logic             x_last, y_last;
  logic [WIDTH:0]   mm_sum;

  // The output register is a one-deep skid: a new pixel may enter only when it drains.
  assign in_ready = (state_q == RUN) && (!ov_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign x_last   = (x_q == XW'(H_RES - 1));
  assign y_last   = (y_q == YW'(V_RES - 1));
  // Extra carry bit keeps the midpoint exact for any min/max pair.
  assign mm_sum   = {1'b0, run_min_q} + {1'b0, run_max_q};

  always_comb begin
    // NOTE: every _d gets its hold value first, so no branch can leave one unassigned (no latches).
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    thresh_d  = thresh_q;
    fmin_d    = fmin_q;
    fmax_d    = fmax_q;
    ov_d      = ov_q;
    oq_d      = oq_q;
    sof_d     = sof_q;
    eol_d     = eol_q;
    eof_d     = eof_q;

    if (ov_q && out_ready) ov_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) begin
          if (manual) thresh_d = thresh_in;
          x_d       = '0;
          y_d       = '0;
          run_min_d = '1;
          run_max_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          ov_d  = 1'b1;
          oq_d  = (in_I > thresh_q) ? HI : LO;
          sof_d = (x_q == '0) && (y_q == '0);
          eol_d = x_last;
          eof_d = x_last && y_last;
          if (in_I < run_min_q) run_min_d = in_I;
          if (in_I > run_max_q) run_max_d = in_I;
          if (x_last) begin
            x_d = '0;
            if (y_last) begin
              y_d     = '0;
              state_d = UPDATE;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      UPDATE: begin
        fmin_d    = run_min_q;
        fmax_d    = run_max_q;
        thresh_d  = manual ? thresh_in : mm_sum[WIDTH:1];
        run_min_d = '1;
        run_max_d = '0;
        state_d   = en ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all of them update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      run_min_q <= '1;
      run_max_q <= '0;
      thresh_q  <= INIT_THRESH;
      fmin_q    <= '0;
      fmax_q    <= '0;
      ov_q      <= 1'b0;
      oq_q      <= LO;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
      eof_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      run_min_q <= run_min_d;
      run_max_q <= run_max_d;
      thresh_q  <= thresh_d;
      fmin_q    <= fmin_d;
      fmax_q    <= fmax_d;
      ov_q      <= ov_d;
      oq_q      <= oq_d;
      sof_q     <= sof_d;
      eol_q     <= eol_d;
      eof_q     <= eof_d;
    end
  end

  assign out_valid = ov_q;
  assign out_q     = oq_q;
  assign out_sof   = sof_q;
  assign out_eol   = eol_q;
  assign out_eof   = eof_q;
  assign thresh    = thresh_q;
  assign frame_min = fmin_q;
  assign frame_max = fmax_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_threshold_ctrl.sv
// Randomized bench for threshold_ctrl on a 4x2 raster, checked cycle by cycle
// against a frame-level reference model (pixel lists, min/max over whole frames).
module tb_threshold_ctrl;

  localparam int H = 4;
  localparam int V = 2;
  localparam int N = H * V;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       manual = 1'b0;
  logic [7:0] thresh_in = 8'd0;
  logic       in_valid = 1'b0;
  logic [7:0] in_I = 8'd0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, out_sof, out_eol, out_eof, busy;
  logic [7:0] out_q, thresh, frame_min, frame_max;

  threshold_ctrl #(.WIDTH(8), .H_RES(H), .V_RES(V), .INIT_THRESH(8'd128)) dut (
    .clk(clk), .reset(reset), .en(en), .manual(manual), .thresh_in(thresh_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_I(in_I),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .thresh(thresh), .frame_min(frame_min), .frame_max(frame_max), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase of the frame controller plus whole-frame bookkeeping.
  typedef enum {M_IDLE, M_RUN, M_UPD} phase_t;
  typedef struct { logic [7:0] q; logic sof, eol, eof; } pix_t;

  phase_t     m_ph = M_IDLE;
  int         m_thresh = 128;
  int         m_fmin = 0;
  int         m_fmax = 0;
  logic [7:0] m_frame[$];
  pix_t       exp_q[$];
  logic [7:0] px[N];

  // One clock: sample/check at negedge+1, advance model, return just after posedge.
  task automatic step(output bit acc);
    bit   e_ov, e_ir;
    int   idx, mn, mx;
    pix_t p;
    @(negedge clk); #1;
    e_ov = (exp_q.size() > 0);
    e_ir = (m_ph == M_RUN) && (!e_ov || out_ready);
    check("out_valid", out_valid, e_ov);
    check("in_ready", in_ready, e_ir);
    check("busy", busy, m_ph != M_IDLE);
    check("thresh", thresh, m_thresh);
    check("frame_min", frame_min, m_fmin);
    check("frame_max", frame_max, m_fmax);
    if (e_ov) begin
      p = exp_q[0];
      check("out_q", out_q, p.q);
      check("out_sof", out_sof, p.sof);
      check("out_eol", out_eol, p.eol);
      check("out_eof", out_eof, p.eof);
      if (out_ready) void'(exp_q.pop_front());
    end
    acc = in_valid && e_ir;
    case (m_ph)
      M_IDLE: if (en) begin
        if (manual) m_thresh = thresh_in;
        m_frame.delete();
        m_ph = M_RUN;
      end
      M_RUN: if (acc) begin
        idx   = m_frame.size();
        p.q   = (int'(in_I) > m_thresh) ? 8'hFF : 8'h00;
        p.sof = (idx == 0);
        p.eol = (idx % H == H - 1);
        p.eof = (idx == N - 1);
        exp_q.push_back(p);
        m_frame.push_back(in_I);
        if (m_frame.size() == N) m_ph = M_UPD;
      end
      M_UPD: begin
        mn = 255; mx = 0;
        foreach (m_frame[i]) begin
          if (m_frame[i] < mn) mn = m_frame[i];
          if (m_frame[i] > mx) mx = m_frame[i];
        end
        m_fmin   = mn;
        m_fmax   = mx;
        m_thresh = manual ? int'(thresh_in) : (mn + mx) / 2;
        m_frame.delete();
        m_ph = en ? M_RUN : M_IDLE;
      end
      default: ;
    endcase
    @(posedge clk); #1;
  endtask

  // Offer px[first .. first+n-1] with given valid/ready percentages.
  task automatic send(input int first, input int n, input int vp, input int rp, input int drop_at);
    int sent = 0;
    int cyc  = 0;
    bit acc;
    while (sent < n && cyc < 300) begin
      in_valid  = ($urandom_range(99) < vp);
      in_I      = px[first + sent];
      out_ready = ($urandom_range(99) < rp);
      step(acc);
      cyc++;
      if (acc) begin
        sent++;
        if (sent == drop_at) en = 1'b0;
      end
    end
    in_valid = 1'b0;
    if (sent < n) check("send_timeout", sent, n);
  endtask

  task automatic idle(input int k);
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < k; i++) step(acc);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_q", out_q, 8'h00);
    check("rst_flags", {out_sof, out_eol, out_eof}, 3'b000);
    check("rst_thresh", thresh, 128);
    check("rst_frame_min", frame_min, 0);
    check("rst_frame_max", frame_max, 0);
    check("rst_busy", busy, 0);
    m_ph = M_IDLE; m_thresh = 128; m_fmin = 0; m_fmax = 0;
    m_frame.delete();
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #2;
    reset_dut();

    // Directed frame with the strict greater-than boundary at 128/129.
    en = 1'b1; manual = 1'b0;
    px = '{8'd10, 8'd200, 8'd50, 8'd128, 8'd129, 8'd0, 8'd255, 8'd90};
    send(0, N, 100, 100, -1);
    idle(4);
    check("t1_thresh", thresh, 127);
    check("t1_min", frame_min, 0);
    check("t1_max", frame_max, 255);

    // Uniform frames: 60s set thresh=60, 60s again all LO, 61s all HI.
    px = '{default: 8'd60};
    send(0, N, 100, 100, -1);
    idle(3);
    check("u_min", frame_min, 60);
    check("u_max", frame_max, 60);
    check("u_thresh", thresh, 60);
    send(0, N, 100, 100, -1);
    px = '{default: 8'd61};
    send(0, N, 100, 100, -1);
    idle(3);

    // Manual threshold requested mid-frame takes effect only at the frame end.
    for (int i = 0; i < N; i++) px[i] = 8'($urandom_range(255));
    send(0, 3, 100, 100, -1);
    manual = 1'b1; thresh_in = 8'd20;
    send(3, N - 3, 100, 100, -1);
    idle(3);
    check("man_thresh", thresh, 20);
    manual = 1'b0;

    // Random backpressure and valid gaps over several frames.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) px[i] = 8'($urandom_range(255));
      send(0, N, 70, 50, -1);
    end
    idle(4);

    // Drop en after the third pixel: frame finishes, then controller parks.
    for (int i = 0; i < N; i++) px[i] = 8'($urandom_range(255));
    send(0, N, 80, 60, 3);
    idle(5);
    check("endrop_busy", busy, 0);
    check("endrop_in_ready", in_ready, 0);

    // Reset mid-frame, then a clean restart from INIT_THRESH.
    en = 1'b1;
    for (int i = 0; i < N; i++) px[i] = 8'($urandom_range(255));
    send(0, 6, 100, 30, -1);
    reset_dut();
    check("restart_thresh", thresh, 128);
    for (int i = 0; i < N; i++) px[i] = 8'($urandom_range(255));
    send(0, N, 90, 70, -1);
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
